pwm_capture: RTL

- Receive-side counterpart of the motor PWM generator: measures an incoming PWM waveform and reports its period and high time in clk cycles.
- Used for closed-loop checks of ena/enb, and for reading externally generated PWM such as servo or sensor duty outputs.
- Sits between an asynchronous pin and the steering/control logic.
- Reports a timeout when the input stops toggling, i.e. a stuck 0% or 100% duty.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 39 +++
 rtl/pwm_capture.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Definitions shared by the PWM generator and the PWM capture block.
//   - pwm_state_e         : capture FSM state encoding
//   - PWM_FRAME           : nominal PWM frame length in clk cycles
//   - PWM_CNT_W           : counter width wide enough for one frame
//   - PWM_TIMEOUT_DEFAULT : stall threshold, two frames without a rising edge
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int unsigned PWM_FRAME           = 250000;
  localparam int unsigned PWM_CNT_W           = 20;
  localparam int unsigned PWM_TIMEOUT_DEFAULT = 2 * PWM_FRAME;

  // ST_ prefix keeps the enum literals clear of the TIMEOUT parameter name.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for asynchronous level inputs (PWM, IR, IPS pins).
//   Each bit is synchronized independently; use only for signals whose bits
//   are not required to change coherently.
//
// Ports
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears both stages to 0
//   d      : asynchronous input(s)
//   q      : synchronized output(s), two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // NOTE: sequential state uses non-blocking assignments so that s2 samples
  // the previous value of s1 rather than the value written in this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule : sync_2ff

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform: the period between the last two rising
//   edges and the high time inside that period, both in clk cycles. Declares a
//   stall (stuck 0% / 100% duty) when no rising edge arrives for TIMEOUT cycles.
//
// Parameters
//   CNT_W   : width of the counters and of period/high_width
//   TIMEOUT : cycles without a rising edge before a stall; 2 <= TIMEOUT < 2**CNT_W
//
// Ports
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   pwm_in      : asynchronous PWM input
//   period      : cycles between the last two rising edges, 0 after a stall
//   high_width  : high cycles within that period, 0 after a stall
//   valid       : one-cycle strobe, period/high_width/timeout/stuck_level updated
//   timeout     : 1 while the input is stalled (until a full period is latched)
//   stuck_level : synchronized input level captured when the stall was declared
// -----------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = PWM_CNT_W,
  parameter int unsigned TIMEOUT = PWM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_width,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input synchronization and rising-edge detection
  // ---------------------------------------------------------------------------
  logic s2;
  logic prev;
  logic rise;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pwm_in),
    .q     (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= s2;
    end
  end

  // Two consecutive rise cycles are impossible: rise forces prev=1 next cycle.
  assign rise = s2 & ~prev;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  pwm_state_e       state;
  pwm_state_e       next_state;
  logic             latch_meas;   // complete period available this cycle
  logic             enter_stall;  // stall declared this cycle
  logic             cnt_hold;     // counters frozen while stalled
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             at_limit;

  assign at_limit = (period_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    next_state  = state;
    latch_meas  = 1'b0;
    enter_stall = 1'b0;

    unique case (state)
      // First rise only arms the measurement: there is no previous edge yet.
      ST_IDLE: begin
        if (rise) begin
          next_state = ST_MEASURE;
        end else if (at_limit) begin
          next_state  = ST_TIMEOUT;
          enter_stall = 1'b1;
        end
      end

      // A rise on the same cycle the limit is reached still latches normally.
      ST_MEASURE: begin
        if (rise) begin
          latch_meas = 1'b1;
        end else if (at_limit) begin
          next_state  = ST_TIMEOUT;
          enter_stall = 1'b1;
        end
      end

      // Restart: the first rise after a stall has no reference edge, so it
      // only re-arms; timeout stays high until a full period is latched.
      ST_TIMEOUT: begin
        if (rise) begin
          next_state = ST_MEASURE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign cnt_hold = (state == ST_TIMEOUT) || enter_stall;

  // ---------------------------------------------------------------------------
  // Period / high-time counters
  //   Reload to 1 on the rise cycle so that the rise cycle itself is counted;
  //   at the next rise period_cnt equals the exact distance between edges.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else if (!cnt_hold) begin
      if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + CNT_ONE;
      end
      if (s2 && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs; valid is a single-cycle strobe one cycle after the
  // latching event.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      high_width  <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (latch_meas) begin
        period     <= period_cnt;
        high_width <= high_cnt;
        timeout    <= 1'b0;
        valid      <= 1'b1;
      end else if (enter_stall) begin
        period      <= '0;
        high_width  <= '0;
        timeout     <= 1'b1;
        stuck_level <= s2;
        valid       <= 1'b1;
      end
    end
  end

endmodule : pwm_capture
